// File: rtl/cc_branch_unit.sv
// Condition-code register, branch-enable register and saturating taken-branch counter.
// Define CC_BYPASS_EN to let a same-edge LD_CC/LD_BEN pair evaluate against freshly decoded flags.
module cc_branch_unit #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] bus_data,
  input  logic [2:0]       IR_nzp,
  input  logic             LD_CC,
  input  logic             LD_BEN,
  input  logic             clr_count,
  output logic [2:0]       NZP,
  output logic             cc_valid,
  output logic             BEN,
  output logic             ben_valid,
  output logic [CNT_W-1:0] taken_count
);

  logic [2:0]       nzp_q, nzp_d;
  logic             cc_valid_q, cc_valid_d;
  logic             ben_q, ben_d;
  logic             ben_valid_q, ben_valid_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [2:0]       flags_dec;
  logic [2:0]       cond_flags;
  logic             cond;

  always_comb begin
    flags_dec = 3'b001;
    if (bus_data[WIDTH-1]) begin
      flags_dec = 3'b100;
    end else if (bus_data == '0) begin
      flags_dec = 3'b010;
    end
  end

`ifdef CC_BYPASS_EN
  // cond is only consumed on LD_BEN edges, so LD_CC alone selects the bypass.
  assign cond_flags = LD_CC ? flags_dec : nzp_q;
`else
  assign cond_flags = nzp_q;
`endif

  // 111 is unconditional even before any CC load, when the register is still 000.
  assign cond = (IR_nzp == 3'b111) || ((IR_nzp & cond_flags) != 3'b000);

  always_comb begin
    nzp_d       = nzp_q;
    cc_valid_d  = cc_valid_q;
    ben_d       = ben_q;
    ben_valid_d = LD_BEN;
    count_d     = count_q;

    if (LD_CC) begin
      nzp_d      = flags_dec;
      cc_valid_d = 1'b1;
    end

    if (LD_BEN) begin
      ben_d = cond;
    end

    if (clr_count) begin
      count_d = '0;
    end else if (LD_BEN && cond && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      nzp_q       <= 3'b000;
      cc_valid_q  <= 1'b0;
      ben_q       <= 1'b0;
      ben_valid_q <= 1'b0;
      count_q     <= '0;
    end else begin
      nzp_q       <= nzp_d;
      cc_valid_q  <= cc_valid_d;
      ben_q       <= ben_d;
      ben_valid_q <= ben_valid_d;
      count_q     <= count_d;
    end
  end

  assign NZP         = nzp_q;
  assign cc_valid    = cc_valid_q;
  assign BEN         = ben_q;
  assign ben_valid   = ben_valid_q;
  assign taken_count = count_q;

endmodule
